// File: rtl/cluster_expander.sv
// cluster_expander: rebuilds per-pad hit maps from a serial stream of
// (vpf, adr, cnt) clusters. One frame is accumulated in a working map and
// handed to a one-entry output buffer with a valid/ready handshake.
module cluster_expander #(
    parameter int MXKEYS    = 384,
    parameter int MXKEYBITS = 9,
    parameter int MXCNTB    = 3,
    parameter int MXNCLB    = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     vpf_i,
    input  logic [MXKEYBITS-1:0]     adr_i,
    input  logic [MXCNTB-1:0]        cnt_i,
    input  logic                     eof_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [MXKEYS-1:0]        vpfs_o,
    output logic [MXKEYS*MXCNTB-1:0] cnts_o,
    output logic [MXKEYS-1:0]        hits_o,
    output logic [MXNCLB-1:0]        nclust_o,
    output logic                     err_adr_o,
    output logic                     drop_o,
    output logic [7:0]               ndrop_o
);

    // One extra bit so adr+cnt past the top pad does not wrap.
    localparam int AW = MXKEYBITS + 1;
    localparam logic [AW-1:0] KEYS_LIMIT = AW'(MXKEYS);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_reg, state_next;
    logic   load, drop;

    logic [MXKEYS-1:0]        work_vpfs_reg, work_vpfs_next;
    logic [MXKEYS*MXCNTB-1:0] work_cnts_reg, work_cnts_next;
    logic [MXKEYS-1:0]        work_hits_reg, work_hits_next;
    logic [MXNCLB-1:0]        work_ncl_reg, work_ncl_next;

    logic [AW-1:0]     adr_ext, adr_end;
    logic              adr_ok, adr_bad;
    logic [MXKEYS-1:0] key_hit, cov_hit;

    assign adr_ext = {1'b0, adr_i};
    assign adr_end = adr_ext + AW'(cnt_i);
    assign adr_ok  = vpf_i && (adr_ext < KEYS_LIMIT);
    assign adr_bad = vpf_i && !(adr_ext < KEYS_LIMIT);

    // Per-pad decode of the incoming cluster; pads above the top simply do
    // not exist, so coverage is truncated there without wrapping.
    generate
        for (genvar gi = 0; gi < MXKEYS; gi++) begin : g_pad
            localparam logic [AW-1:0] PAD = AW'(gi);
            assign key_hit[gi] = adr_ok && (adr_ext == PAD);
            assign cov_hit[gi] = adr_ok && (PAD >= adr_ext) && (PAD <= adr_end);
            assign work_cnts_next[gi*MXCNTB +: MXCNTB] =
                key_hit[gi] ? cnt_i : work_cnts_reg[gi*MXCNTB +: MXCNTB];
        end
    endgenerate

    assign work_vpfs_next = work_vpfs_reg | key_hit;
    assign work_hits_next = work_hits_reg | cov_hit;
    assign work_ncl_next  = (adr_ok && (work_ncl_reg != '1)) ? work_ncl_reg + 1'b1
                                                             : work_ncl_reg;

    // Output buffer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= EMPTY;
        else       state_reg <= state_next;
    end

    // Buffer next state: a close while FULL reloads if the old frame is
    // being taken this cycle, otherwise the new frame is dropped.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (eof_i) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (eof_i) begin
                    if (ready_i) load = 1'b1;
                    else         drop = 1'b1;
                end else if (ready_i) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Working map: accumulate clusters, cleared at the edge that closes a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work_vpfs_reg <= '0;
            work_cnts_reg <= '0;
            work_hits_reg <= '0;
            work_ncl_reg  <= '0;
        end else if (eof_i) begin
            work_vpfs_reg <= '0;
            work_cnts_reg <= '0;
            work_hits_reg <= '0;
            work_ncl_reg  <= '0;
        end else begin
            work_vpfs_reg <= work_vpfs_next;
            work_cnts_reg <= work_cnts_next;
            work_hits_reg <= work_hits_next;
            work_ncl_reg  <= work_ncl_next;
        end
    end

    // Output buffer data, including the cluster arriving with eof.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpfs_o   <= '0;
            cnts_o   <= '0;
            hits_o   <= '0;
            nclust_o <= '0;
        end else if (load) begin
            vpfs_o   <= work_vpfs_next;
            cnts_o   <= work_cnts_next;
            hits_o   <= work_hits_next;
            nclust_o <= work_ncl_next;
        end
    end

    assign valid_o = (state_reg == FULL);

    // Status pulses and the saturating drop counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_adr_o <= 1'b0;
            drop_o    <= 1'b0;
            ndrop_o   <= '0;
        end else begin
            err_adr_o <= adr_bad;
            drop_o    <= drop;
            if (drop && (ndrop_o != 8'hFF)) ndrop_o <= ndrop_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_cluster_expander.sv
// Testbench for cluster_expander: directed scenarios plus randomized frames
// checked against a behavioural frame model.
module tb_cluster_expander;

    localparam int NK = 384;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vpf_i = 1'b0;
    logic [8:0]    adr_i = '0;
    logic [2:0]    cnt_i = '0;
    logic          eof_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [NK-1:0] vpfs_o;
    logic [NK*3-1:0] cnts_o;
    logic [NK-1:0] hits_o;
    logic [5:0]    nclust_o;
    logic          err_adr_o;
    logic          drop_o;
    logic [7:0]    ndrop_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: working frame, held frame and status.
    logic [NK-1:0]   m_vpfs, e_vpfs;
    logic [NK*3-1:0] m_cnts, e_cnts;
    logic [NK-1:0]   m_hits, e_hits;
    int              m_ncl, e_ncl;
    bit              m_full, m_err, m_drop;
    int              m_ndrop;

    cluster_expander dut (
        .clock(clock), .reset(reset), .vpf_i(vpf_i), .adr_i(adr_i), .cnt_i(cnt_i),
        .eof_i(eof_i), .ready_i(ready_i), .valid_o(valid_o), .vpfs_o(vpfs_o),
        .cnts_o(cnts_o), .hits_o(hits_o), .nclust_o(nclust_o), .err_adr_o(err_adr_o),
        .drop_o(drop_o), .ndrop_o(ndrop_o)
    );

    always #5 clock = ~clock;

    function automatic int first_cnt_diff(input logic [NK*3-1:0] a, input logic [NK*3-1:0] b);
        for (int p = 0; p < NK; p++)
            if (a[p*3 +: 3] !== b[p*3 +: 3]) return p;
        return -1;
    endfunction

    function automatic int lowest_set(input logic [NK-1:0] v);
        for (int p = 0; p < NK; p++)
            if (v[p]) return p;
        return -1;
    endfunction

    task automatic model_clear_work();
        m_vpfs = '0; m_cnts = '0; m_hits = '0; m_ncl = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; vpf_i = 0; eof_i = 0; ready_i = 0; adr_i = '0; cnt_i = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear_work();
        e_vpfs = '0; e_cnts = '0; e_hits = '0; e_ncl = 0;
        m_full = 0; m_err = 0; m_drop = 0; m_ndrop = 0;
        #1;
    endtask

    // One clock cycle of stimulus, with the model advanced by the same cycle.
    task automatic cycle(input bit vpf, input int adr, input int cnt, input bit eof, input bit rdy);
        vpf_i = vpf; adr_i = adr[8:0]; cnt_i = cnt[2:0]; eof_i = eof; ready_i = rdy;
        m_err = vpf && (adr >= NK);
        m_drop = 0;
        if (vpf && adr < NK) begin
            m_vpfs[adr] = 1'b1;
            m_cnts[adr*3 +: 3] = cnt[2:0];
            for (int p = adr; p <= adr + cnt && p < NK; p++) m_hits[p] = 1'b1;
            if (m_ncl < 63) m_ncl++;
        end
        if (eof) begin
            if (!m_full || rdy) begin
                e_vpfs = m_vpfs; e_cnts = m_cnts; e_hits = m_hits; e_ncl = m_ncl;
                m_full = 1;
            end else begin
                m_drop = 1;
                if (m_ndrop < 255) m_ndrop++;
            end
            model_clear_work();
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        @(posedge clock); #1;
        vpf_i = 0; eof_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (valid_o !== 1'b0 || err_adr_o !== 1'b0 || drop_o !== 1'b0 || ndrop_o !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_status: valid=%b err=%b drop=%b ndrop=%0d, want all 0",
                     valid_o, err_adr_o, drop_o, ndrop_o);
        end
        tests_run++;
        if (vpfs_o !== '0 || hits_o !== '0 || cnts_o !== '0 || nclust_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_data: vpfs/hits/cnts/nclust not zero (nclust=%0d)", nclust_o);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        cycle(1, 10, 2, 1, 1);
        tests_run++;
        if (valid_o !== 1'b1 || vpfs_o !== (NK'(1) << 10) || nclust_o !== 6'd1) begin
            tests_failed++;
            $display("FAIL single_vpf: valid=%b low_vpf=%0d ncl=%0d, want 1/10/1",
                     valid_o, lowest_set(vpfs_o), nclust_o);
        end
        tests_run++;
        if (hits_o[12:10] !== 3'b111 || $countones(hits_o) != 3 || cnts_o[32:30] !== 3'd2) begin
            tests_failed++;
            $display("FAIL single_hits: hits[12:10]=%b ones=%0d cnt10=%0d, want 111/3/2",
                     hits_o[12:10], $countones(hits_o), cnts_o[32:30]);
        end
        tests_run++;
        if (first_cnt_diff(cnts_o, e_cnts) != -1) begin
            tests_failed++;
            $display("FAIL single_cnts: first differing pad %0d", first_cnt_diff(cnts_o, e_cnts));
        end
        cycle(0, 0, 0, 0, 1);
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pop: valid=%b want 0", valid_o);
        end
        $display("[TB] single cluster adr=10 cnt=2");
    endtask

    task automatic test_truncation();
        cycle(1, 382, 7, 1, 1);
        tests_run++;
        if (hits_o[383:382] !== 2'b11 || $countones(hits_o) != 2 || vpfs_o[382] !== 1'b1 ||
            nclust_o !== 6'd1 || cnts_o[382*3 +: 3] !== 3'd7) begin
            tests_failed++;
            $display("FAIL truncation: hits_top=%b ones=%0d vpf382=%b ncl=%0d cnt=%0d, want 11/2/1/1/7",
                     hits_o[383:382], $countones(hits_o), vpfs_o[382], nclust_o, cnts_o[382*3 +: 3]);
        end
        tests_run++;
        if (hits_o[0] !== 1'b0 || hits_o[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL truncation_wrap: hits[1:0]=%b want 00", hits_o[1:0]);
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] truncation adr=382 cnt=7");
    endtask

    task automatic test_invalid_adr();
        cycle(1, 511, 3, 1, 1);
        tests_run++;
        if (err_adr_o !== 1'b1 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL invalid_err: err=%b valid=%b want 1/1", err_adr_o, valid_o);
        end
        tests_run++;
        if (vpfs_o !== '0 || hits_o !== '0 || cnts_o !== '0 || nclust_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL invalid_frame: ncl=%0d ones=%0d, want empty frame",
                     nclust_o, $countones(hits_o));
        end
        cycle(1, 384, 0, 0, 1);
        tests_run++;
        if (err_adr_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL invalid_384: err=%b want 1", err_adr_o);
        end
        cycle(0, 450, 1, 0, 1);
        tests_run++;
        if (err_adr_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_novpf: err=%b want 0", err_adr_o);
        end
        cycle(0, 0, 0, 1, 1);
        tests_run++;
        if (nclust_o !== 6'd0 || vpfs_o !== '0) begin
            tests_failed++;
            $display("FAIL invalid_count: ncl=%0d want 0", nclust_o);
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] invalid address");
    endtask

    task automatic test_overwrite();
        cycle(1, 5, 1, 0, 1);
        cycle(1, 5, 4, 1, 1);
        tests_run++;
        if (cnts_o[17:15] !== 3'd4 || hits_o[9:5] !== 5'b11111 || $countones(hits_o) != 5 ||
            nclust_o !== 6'd2 || $countones(vpfs_o) != 1) begin
            tests_failed++;
            $display("FAIL overwrite: cnt5=%0d hits[9:5]=%b ones=%0d ncl=%0d, want 4/11111/5/2",
                     cnts_o[17:15], hits_o[9:5], $countones(hits_o), nclust_o);
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] overwrite at adr=5");
    endtask

    task automatic test_drop();
        cycle(1, 20, 3, 1, 0);
        cycle(1, 100, 0, 1, 0);
        tests_run++;
        if (drop_o !== 1'b1 || ndrop_o !== 8'd1 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_pulse: drop=%b ndrop=%0d valid=%b want 1/1/1", drop_o, ndrop_o, valid_o);
        end
        tests_run++;
        if (vpfs_o[20] !== 1'b1 || vpfs_o[100] !== 1'b0 || hits_o !== e_hits || nclust_o !== 6'd1) begin
            tests_failed++;
            $display("FAIL drop_kept: vpf20=%b vpf100=%b ncl=%0d want 1/0/1", vpfs_o[20], vpfs_o[100], nclust_o);
        end
        cycle(1, 200, 1, 0, 0);
        tests_run++;
        if (drop_o !== 1'b0 || vpfs_o !== e_vpfs || hits_o !== e_hits || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_stable: drop=%b valid=%b vpf stable=%b", drop_o, valid_o, vpfs_o === e_vpfs);
        end
        cycle(0, 0, 0, 0, 1);
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_pop: valid=%b want 0", valid_o);
        end
        cycle(0, 0, 0, 1, 1);
        tests_run++;
        if (vpfs_o[200] !== 1'b1 || nclust_o !== 6'd1) begin
            tests_failed++;
            $display("FAIL drop_nextframe: vpf200=%b ncl=%0d want 1/1", vpfs_o[200], nclust_o);
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] drop while full");
    endtask

    task automatic test_back_to_back();
        cycle(1, 30, 1, 1, 1);
        cycle(1, 40, 2, 1, 1);
        tests_run++;
        if (valid_o !== 1'b1 || drop_o !== 1'b0 || vpfs_o[40] !== 1'b1 || vpfs_o[30] !== 1'b0 ||
            hits_o[42:40] !== 3'b111 || $countones(hits_o) != 3) begin
            tests_failed++;
            $display("FAIL back_to_back: valid=%b drop=%b vpf40=%b vpf30=%b ones=%0d",
                     valid_o, drop_o, vpfs_o[40], vpfs_o[30], $countones(hits_o));
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] back-to-back frames");
    endtask

    task automatic test_reset_midframe();
        cycle(1, 1, 0, 1, 0);
        cycle(1, 50, 2, 0, 0);
        do_reset();
        tests_run++;
        if (valid_o !== 1'b0 || ndrop_o !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_valid: valid=%b ndrop=%0d want 0/0", valid_o, ndrop_o);
        end
        cycle(0, 0, 0, 1, 1);
        tests_run++;
        if (valid_o !== 1'b1 || vpfs_o !== '0 || hits_o !== '0 || nclust_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL midreset_frame: valid=%b ncl=%0d ones=%0d want 1/0/0",
                     valid_o, nclust_o, $countones(hits_o));
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] reset mid-frame");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 70; i++) cycle(1, (i * 5) % NK, $urandom_range(0, 7), i == 69, 1);
        tests_run++;
        if (nclust_o !== 6'd63 || hits_o !== e_hits || vpfs_o !== e_vpfs) begin
            tests_failed++;
            $display("FAIL nclust_sat: ncl=%0d want 63", nclust_o);
        end
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 260; i++) cycle(0, 0, 0, 1, 0);
        tests_run++;
        if (ndrop_o !== 8'd255 || drop_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ndrop_sat: ndrop=%0d drop=%b want 255/1", ndrop_o, drop_o);
        end
        cycle(0, 0, 0, 0, 1);
        $display("[TB] counter saturation");
    endtask

    task automatic test_random();
        int n, adr, cnt, min_adr, min_cnt, lo;
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(0, 16);
            min_adr = -1; min_cnt = 0;
            for (int c = 0; c <= n; c++) begin
                if ($urandom_range(0, 3) == 0) cycle(0, $urandom_range(0, 511), $urandom_range(0, 7), c == n, 1);
                else begin
                    adr = ($urandom_range(0, 9) == 0) ? $urandom_range(384, 511) : $urandom_range(0, 383);
                    cnt = $urandom_range(0, 7);
                    if (adr < NK && (min_adr < 0 || adr <= min_adr)) begin
                        min_adr = adr; min_cnt = cnt;
                    end
                    cycle(1, adr, cnt, c == n, 1);
                end
            end
            lo = lowest_set(vpfs_o);
            tests_run++;
            if (valid_o !== 1'b1 || vpfs_o !== e_vpfs || hits_o !== e_hits ||
                nclust_o !== 6'(e_ncl) || first_cnt_diff(cnts_o, e_cnts) != -1) begin
                tests_failed++;
                $display("FAIL random_frame%0d: valid=%b ncl=%0d/%0d cntdiff=%0d vpf_ok=%b hit_ok=%b",
                         f, valid_o, nclust_o, e_ncl, first_cnt_diff(cnts_o, e_cnts),
                         vpfs_o === e_vpfs, hits_o === e_hits);
            end
            tests_run++;
            if (lo != min_adr || (lo >= 0 && cnts_o[lo*3 +: 3] != 3'(min_cnt))) begin
                tests_failed++;
                $display("FAIL random_encode%0d: first key %0d want %0d",
                         f, lo, min_adr);
            end
            $display("[TB] random frame %0d clusters=%0d first=%0d", f, n, min_adr);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_truncation();
        test_invalid_adr();
        test_overwrite();
        test_drop();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
